// File: rtl/pc_fetch_unit_pkg.sv
// Shared types and constants for the program-counter fetch stage.
// Imported by the fetch interface and the fetch unit.
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int unsigned LUT_IDX_W = 8;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Control/status bundle between the sequencer driving a program run and the fetch unit.
// The fetch unit uses the slave view; the driving side uses the master view.
interface pc_fetch_unit_if
    import fetch_pkg::*;
#(
    parameter int unsigned D     = 10,
    parameter int unsigned CNT_W = 16
) ();

    logic                 start;
    logic                 stall;
    logic                 branch_en;
    logic [LUT_IDX_W-1:0] branch_idx;
    logic                 halt_req;
    logic [D-1:0]         target;
    logic [D-1:0]         prog_ctr;
    logic [LUT_IDX_W-1:0] lut_addr;
    logic                 running;
    logic                 done;
    logic [CNT_W-1:0]     retired;

    modport master (
        output start,
        output stall,
        output branch_en,
        output branch_idx,
        output halt_req,
        output target,
        input  prog_ctr,
        input  lut_addr,
        input  running,
        input  done,
        input  retired
    );

    modport slave (
        input  start,
        input  stall,
        input  branch_en,
        input  branch_idx,
        input  halt_req,
        input  target,
        output prog_ctr,
        output lut_addr,
        output running,
        output done,
        output retired
    );

endinterface

// File: rtl/pc_fetch_unit.sv
// Program-counter stage: sequences the PC (increment/jump/hold/halt), drives the
// branch-target LUT index, and counts retired instructions for each program run.
module pc_fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned D     = 10,
    parameter int unsigned CNT_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    pc_fetch_unit_if.slave bus
);

    fetch_state_t     state;
    fetch_state_t     state_n;
    logic [D-1:0]     pc;
    logic [D-1:0]     pc_n;
    logic [CNT_W-1:0] ret;
    logic [CNT_W-1:0] ret_n;
    logic [CNT_W-1:0] ret_inc;

    // Retired count saturates at all-ones instead of wrapping.
    assign ret_inc = (ret == '1) ? ret : ret + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pc    <= '0;
            ret   <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            ret   <= ret_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        ret_n   = ret;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n = RUN;
                    pc_n    = '0;
                    ret_n   = '0;
                end
            end
            RUN: begin
                // start is ignored while running; stall masks branch and halt.
                if (!bus.stall) begin
                    ret_n = ret_inc;
                    if (bus.halt_req) begin
                        state_n = HALTED;
                    end else if (bus.branch_en) begin
                        pc_n = bus.target;
                    end else begin
                        pc_n = pc + D'(1);
                    end
                end
            end
            HALTED: begin
                if (bus.start) begin
                    state_n = RUN;
                    pc_n    = '0;
                    ret_n   = '0;
                end
            end
            default: begin
                state_n = IDLE;
                pc_n    = '0;
                ret_n   = '0;
            end
        endcase
    end

    assign bus.prog_ctr = pc;
    assign bus.lut_addr = bus.branch_idx;
    assign bus.running  = (state == RUN);
    assign bus.done     = (state == HALTED);
    assign bus.retired  = ret;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Scoreboard bench for pc_fetch_unit: directed scenarios plus random traffic,
// checked against a behavioural model of the program-counter rules.
module tb_pc_fetch_unit;

    localparam int unsigned D       = 10;
    localparam int unsigned CNT_W   = 10;
    localparam int          PC_MOD  = 1 << D;
    localparam int          CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        int pc;
        int ret;
        int run;
        int dn;
        int lut;
    } exp_t;

    logic clk;
    logic reset;
    exp_t exp_q[$];

    int n_checks;
    int n_fail;

    // model: mode 0 = idle, 1 = running, 2 = halted
    int m_mode;
    int m_pc;
    int m_ret;

    pc_fetch_unit_if #(.D(D), .CNT_W(CNT_W)) bus ();

    pc_fetch_unit #(.D(D), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    // Applies one cycle of inputs and records what the outputs must be after the edge.
    task automatic step(input bit rst, input bit st, input bit sl, input bit br,
                        input int idx, input bit hr, input int tg);
        exp_t e;
        @(negedge clk);
        reset          = rst;
        bus.start      = st;
        bus.stall      = sl;
        bus.branch_en  = br;
        bus.branch_idx = idx[7:0];
        bus.halt_req   = hr;
        bus.target     = tg[D-1:0];
        if (rst) begin
            m_mode = 0; m_pc = 0; m_ret = 0;
        end else if (m_mode != 1) begin
            if (st) begin
                m_mode = 1; m_pc = 0; m_ret = 0;
            end
        end else if (!sl) begin
            m_ret = (m_ret < CNT_MAX) ? m_ret + 1 : CNT_MAX;
            if (hr)      m_mode = 2;
            else if (br) m_pc = tg % PC_MOD;
            else         m_pc = (m_pc + 1) % PC_MOD;
        end
        e.pc  = m_pc;
        e.ret = m_ret;
        e.run = (m_mode == 1) ? 1 : 0;
        e.dn  = (m_mode == 2) ? 1 : 0;
        e.lut = idx & 8'hff;
        exp_q.push_back(e);
    endtask

    task automatic plain(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic jump(input int tg);
        step(0, 0, 0, 1, $urandom_range(0, 255), 0, tg);
    endtask

    // Monitor: compares every recorded expectation just after the edge it belongs to.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("prog_ctr", int'(bus.prog_ctr), e.pc);
                check("retired",  int'(bus.retired),  e.ret);
                check("running",  int'(bus.running),  e.run);
                check("done",     int'(bus.done),     e.dn);
                check("lut_addr", int'(bus.lut_addr), e.lut);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: got no completion, expected finish before 1000000");
        $fatal(1, "timeout");
    end

    initial begin
        n_checks = 0; n_fail = 0;
        m_mode = 0; m_pc = 0; m_ret = 0;
        reset = 1'b1;
        bus.start = 0; bus.stall = 0; bus.branch_en = 0;
        bus.branch_idx = '0; bus.halt_req = 0; bus.target = '0;

        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 0, 1, 1, 9, 1, 55);          // idle ignores everything but start

        // start, five plain cycles
        step(0, 1, 0, 0, 0, 0, 0);
        plain(5);
        step(0, 1, 0, 0, 0, 0, 0);           // start ignored while running

        // branch at PC=4 to 285 via LUT index 2
        step(1, 0, 0, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0);
        plain(4);
        step(0, 0, 0, 1, 2, 0, 285);
        plain(2);

        // stall with branch pending for three cycles, then the jump goes once
        for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 7, 0, 600);
        step(0, 0, 0, 1, 7, 0, 600);
        plain(1);

        // wrap from 1023 to 0, and a jump to target 0
        jump(1023);
        plain(2);
        jump(0);
        plain(1);

        // halt and branch together at PC=102: halt wins
        jump(102);
        step(0, 0, 0, 1, 3, 1, 500);
        step(0, 0, 1, 1, 4, 1, 77);          // halted ignores non-start inputs
        plain(2);
        step(0, 1, 0, 0, 0, 0, 0);
        plain(3);

        // reset mid-run at PC=37
        jump(37);
        step(1, 1, 0, 1, 5, 0, 99);
        plain(2);

        // retired saturation
        step(0, 1, 0, 0, 0, 0, 0);
        plain(CNT_MAX + 8);
        step(0, 0, 0, 0, 0, 1, 0);
        plain(2);

        // random traffic
        for (int i = 0; i < 2500; i++) begin
            bit rst, st, sl, br, hr;
            int tg;
            rst = ($urandom_range(0, 99) == 0);
            st  = ($urandom_range(0, 19) == 0);
            sl  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 3) == 0);
            hr  = ($urandom_range(0, 29) == 0);
            tg  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, PC_MOD - 1));
            step(rst, st, sl, br, int'($urandom_range(0, 255)), hr, tg);
        end

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
